// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a decoupled prefetch FIFO. Runs ahead of decode over a req/ack
// instruction-memory handshake; redirects flush the queue and restart fetch at the target.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready,
  input  logic [2:0]  redirect_sel,
  input  logic [31:0] redirect_base,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] rs_data,
  input  logic [29:0] epc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [31:0]     ins_mem_q [DEPTH];
  logic [31:0]     pc_mem_q  [DEPTH];

  logic        redirect, push, pop;
  logic [31:0] pc_plus4, target;

  assign redirect = (redirect_sel >= 3'd1) && (redirect_sel <= 3'd5);

  always_comb begin
    pc_plus4 = redirect_base + 32'd4;
    case (redirect_sel)
      3'd1:    target = pc_plus4 + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
      3'd2:    target = {pc_plus4[31:28], redirect_imm, 2'b00};
      3'd3:    target = rs_data & 32'hFFFF_FFFC;
      3'd4:    target = {epc, 2'b00};
      default: target = EXC_VECTOR;
    endcase
  end

  // Request is gated by reset so memory never sees a fetch while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fpc_q;
    case (state_q)
      StRun:   imem_req = (count_q < Full);
      StWait, StFlush: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
    if (reset) imem_req = 1'b0;
  end

  assign ins_valid = (count_q != '0);
  assign ins       = ins_mem_q[rd_ptr_q];
  assign ins_pc    = pc_mem_q[rd_ptr_q];

  assign push = imem_req & imem_ack & (state_q != StFlush) & ~redirect;
  assign pop  = ins_valid & ins_ready & ~redirect;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = (state_q == StRun) ? fpc_q : req_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fpc_d    = target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // An unacknowledged request must still be drained before the target is fetched.
      state_d  = (imem_req & ~imem_ack) ? StFlush : StRun;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        fpc_d    = fpc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
      case (state_q)
        StRun:           if (imem_req && !imem_ack) state_d = StWait;
        StWait, StFlush: if (imem_ack) state_d = StRun;
        default:         state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      fpc_q      <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else if (push) begin
      ins_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]  <= imem_addr;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed redirect-target table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based transaction model.
module tb_ifu_prefetch;

  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic [2:0]  redirect_sel;
  logic [31:0] redirect_base;
  logic [25:0] redirect_imm;
  logic [31:0] rs_data;
  logic [29:0] epc;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ins_valid    (ins_valid),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .ins_ready    (ins_ready),
    .redirect_sel (redirect_sel),
    .redirect_base(redirect_base),
    .redirect_imm (redirect_imm),
    .rs_data      (rs_data),
    .epc          (epc)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model: queue of {pc, instruction}, next fetch pc, and at most one pending request.
  logic [63:0] q[$];
  logic [31:0] m_fpc, m_paddr;
  bit          m_pend, m_disc;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] base;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [29:0] ep;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] tgt(input logic [2:0] sel, input logic [31:0] base,
                                      input logic [25:0] imm, input logic [31:0] rs,
                                      input logic [29:0] ep);
    case (sel)
      3'd1:    return base + 32'd4 + {{16{imm[15]}}, imm[15:0]} * 32'd4;
      3'd2:    return ((base + 32'd4) & 32'hF000_0000) | ({6'd0, imm} * 32'd4);
      3'd3:    return rs & 32'hFFFF_FFFC;
      3'd4:    return {2'b00, ep} * 32'd4;
      default: return EXC_VECTOR;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc  = RESET_PC;
    m_pend = 1'b0;
    m_disc = 1'b0;
  endtask

  // Called at a negedge: check outputs against the model, drive one cycle of inputs,
  // advance the model, and return at the next negedge.
  task automatic step(input bit ack, input bit rdy, input logic [2:0] sel,
                      input logic [31:0] base, input logic [25:0] imm,
                      input logic [31:0] rs, input logic [29:0] ep);
    bit          exp_req;
    logic [31:0] exp_addr;
    exp_req  = m_pend || (q.size() < DEPTH);
    exp_addr = m_pend ? m_paddr : m_fpc;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    chk("ins_valid", {31'd0, ins_valid}, {31'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      chk("ins_pc", ins_pc, q[0][63:32]);
      chk("ins", ins, q[0][31:0]);
    end
    imem_ack      = ack;
    imem_rdata    = ack ? memdata(imem_addr) : $urandom();
    ins_ready     = rdy;
    redirect_sel  = sel;
    redirect_base = base;
    redirect_imm  = imm;
    rs_data       = rs;
    epc           = ep;
    if (sel >= 3'd1 && sel <= 3'd5) begin
      q.delete();
      m_fpc   = tgt(sel, base, imm, rs, ep);
      m_pend  = exp_req && !ack;
      m_paddr = exp_addr;
      m_disc  = m_pend;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (exp_req && ack) begin
        if (!m_disc) begin
          q.push_back({exp_addr, memdata(exp_addr)});
          m_fpc = exp_addr + 32'd4;
        end
        m_pend = 1'b0;
        m_disc = 1'b0;
      end else if (exp_req) begin
        m_pend  = 1'b1;
        m_paddr = exp_addr;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ack, input bit rdy);
    repeat (n) step(ack, rdy, 3'd0, 32'd0, 26'd0, 32'd0, 30'd0);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'd0;
    ins_ready    = 1'b0;
    redirect_sel = 3'd0;
    @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; ins_ready = 1'b0; redirect_sel = '0;
    redirect_base = '0; redirect_imm = '0; rs_data = '0; epc = '0;

    vecs[0] = '{3'd1, 32'h0000_3008, 26'h000_FFFE, 32'd0, 30'd0, 32'h0000_3004};
    vecs[1] = '{3'd2, 32'h0000_0100, 26'h000_0C01, 32'd0, 30'd0, 32'h0000_3004};
    vecs[2] = '{3'd4, 32'h0000_0000, 26'h000_0000, 32'd0, 30'h0C00, 32'h0000_3000};
    vecs[3] = '{3'd5, 32'h1234_5678, 26'h3FF_FFFF, 32'd0, 30'd0, 32'h0000_4180};
    vecs[4] = '{3'd3, 32'h0000_0000, 26'h000_0000, 32'h0000_3013, 30'd0, 32'h0000_3010};
    vecs[5] = '{3'd1, 32'hFFFF_FFF8, 26'h000_0000, 32'd0, 30'd0, 32'hFFFF_FFFC};
    vecs[6] = '{3'd2, 32'h7FFF_FFFC, 26'h3FF_FFFF, 32'd0, 30'd0, 32'h8FFF_FFFC};
    vecs[7] = '{3'd1, 32'h0000_0010, 26'h000_8000, 32'd0, 30'd0, 32'hFFFE_0014};

    // Reset and zero-wait streaming.
    do_reset();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 6; i++) begin
      idle(1, 1'b1, 1'b1);
      chk("stream_pc", ins_pc, RESET_PC + 32'(4 * i));
    end

    // Back-pressure: fill the queue, then drain.
    do_reset();
    idle(6, 1'b1, 1'b0);
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_addr", imem_addr, 32'h0000_3010);
    chk("full_head", ins_pc, 32'h0000_3000);
    idle(8, 1'b1, 1'b1);

    // Redirect target table with zero-wait memory.
    for (int v = 0; v < 8; v++) begin
      idle(2, 1'b1, 1'b1);
      step(1'b1, 1'b1, vecs[v].sel, vecs[v].base, vecs[v].imm, vecs[v].rs, vecs[v].ep);
      chk("redir_req", {31'd0, imem_req}, 32'd1);
      chk("redir_addr", imem_addr, vecs[v].exp);
      idle(1, 1'b1, 1'b1);
      chk("redir_valid", {31'd0, ins_valid}, 32'd1);
      chk("redir_pc", ins_pc, vecs[v].exp);
      chk("redir_next", imem_addr, vecs[v].exp + 32'd4);
    end

    // Redirect while a slow request is outstanding.
    do_reset();
    idle(1, 1'b1, 1'b1);
    idle(1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd5, 32'd0, 26'd0, 32'd0, 30'd0);
    chk("flush_addr", imem_addr, 32'h0000_3004);
    idle(1, 1'b0, 1'b1);
    chk("flush_hold", imem_addr, 32'h0000_3004);
    idle(1, 1'b1, 1'b1);
    chk("stale_no_push", {31'd0, ins_valid}, 32'd0);
    chk("after_stale_addr", imem_addr, EXC_VECTOR);
    idle(1, 1'b1, 1'b1);
    chk("exc_pc", ins_pc, EXC_VECTOR);

    // Redirect coinciding with ack and pop.
    do_reset();
    idle(2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3'd4, 32'd0, 26'd0, 32'd0, 30'h400);
    chk("coinc_valid", {31'd0, ins_valid}, 32'd0);
    chk("coinc_req", {31'd0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h0000_1000);

    // Asynchronous reset in the middle of a wait.
    do_reset();
    idle(1, 1'b1, 1'b1);
    idle(1, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_valid", {31'd0, ins_valid}, 32'd0);
    chk("async_ins", ins, 32'd0);
    chk("async_ins_pc", ins_pc, 32'd0);
    do_reset();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, RESET_PC);

    // Randomized traffic at several memory speeds.
    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < 1000; i++) begin
        int unsigned pct;
        logic [2:0]  sel;
        pct = (seg == 0) ? 100 : ((seg == 1) ? 60 : 30);
        sel = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        step(($urandom_range(0, 99) < pct), ($urandom_range(0, 3) != 0), sel,
             $urandom() & 32'hFFFF_FFFC, 26'($urandom()), $urandom(), 30'($urandom()));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit with a decoupled prefetch queue. It runs ahead of decode: it issues sequential word fetches over a req/ack instruction-memory handshake and buffers {pc, instruction} pairs in a DEPTH-entry FIFO. A redirect (branch, jump, register jump, exception return, interrupt) flushes the queue and restarts fetch from the computed target. The block sits between the instruction memory and the decode stage, replacing the single-register fetch stage.

## Interface
- RESET_PC, 32'h0000_3000, fetch address after reset
- EXC_VECTOR, 32'h0000_4180, interrupt/exception target
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- imem_req  output  1  fetch request
- imem_addr  output  32  word address of request, byte-addressed, [1:0]=00
- imem_ack  input  1  request complete; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- ins_valid  output  1  FIFO head valid
- ins  output  32  head instruction
- ins_pc  output  32  head instruction address
- ins_ready  input  1  decode consumes head when ins_valid & ins_ready
- redirect_sel  input  3  0 none, 1 relative, 2 absolute, 3 register, 4 EPC, 5 interrupt; 6/7 treated as 0
- redirect_base  input  32  pc of the redirecting instruction
- redirect_imm  input  26  instruction immediate field
- rs_data  input  32  register jump target
- epc  input  30  exception return address [31:2]

## Operation
- Registers: fpc (next fetch address), req_addr (address of the outstanding request), FIFO storage, rd/wr pointers, count (0..DEPTH), state.
- Targets: relative = redirect_base + 4 + (sext(imm[15:0]) << 2); absolute = {(redirect_base+4)[31:28], imm, 2'b00}; register = {rs_data[31:2], 2'b00}; EPC = {epc, 2'b00}; interrupt = EXC_VECTOR. All arithmetic is mod 2^32.
- FSM states:
  - RUN: imem_req = (count < DEPTH), imem_addr = fpc.
  - WAIT: imem_req = 1, imem_addr = req_addr.
  - FLUSH: imem_req = 1, imem_addr = req_addr; the response will be discarded.
- RUN, request issued: on same-cycle ack, push {fpc, imem_rdata}, fpc += 4, stay in RUN; otherwise req_addr <= fpc and go to WAIT.
- WAIT, on ack: push {req_addr, imem_rdata}, fpc += 4, go to RUN.
- FLUSH, on ack: drop the data, go to RUN.
- Memory handshake: once imem_req is high, imem_req and imem_addr are held stable until imem_ack. At most one request is outstanding. imem_ack while imem_req is low is ignored.
- Pop: when ins_valid & ins_ready, advance rd pointer. Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_sel in 1..5) has priority over push and pop:
  - count <= 0, pointers reset, fpc <= target.
  - If a request is outstanding and not acked this cycle, go to FLUSH; otherwise go to RUN.
  - A same-cycle ack is dropped. A same-cycle pop is ignored; the head is already flushed.
- Full: no request is issued while count == DEPTH. A push can never overflow.
- fpc wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset (async): state RUN, fpc = RESET_PC, count 0, ins_valid 0, ins 0, ins_pc 0. imem_req is 0 while reset is high, then 1 with imem_addr = RESET_PC in the first cycle after release.
- ins, ins_pc and ins_valid come from registers and FIFO storage, never combinationally from imem_rdata. Pushed data appears at the head one cycle after ack.
- Zero-wait memory (ack in the request cycle): one instruction per cycle sustained.
- Redirect in cycle t with no outstanding request: the target is requested in t+1 and is visible at ins/ins_pc in t+2 with zero-wait memory.
- Redirect during WAIT: the stale ack is consumed in FLUSH; the target is requested in the cycle after that ack.
- Reset mid-request: the state is abandoned. Memory must tolerate imem_req dropping without ack.

## Test plan
- Reset, zero-wait memory, ins_ready=1 -> ins_pc sequence 3000, 3004, 3008… one per cycle; first ins_valid 2 cycles after reset release.
- ins_ready=0, DEPTH=4 -> exactly 4 acks, then imem_req=0 with imem_addr holding 3010; raising ins_ready resumes fetch, no loss or duplication.
- Relative redirect, base=3008, imm[15:0]=FFFE -> next ins_pc 3004; absolute, imm=0000C01 -> 00003004; EPC=0C00 -> 3000; interrupt -> 4180; register rs_data=3013 -> 3010.
- Memory with 3-cycle ack, redirect issued in WAIT -> old data dropped, no FIFO push; next request addresses the target after the stale ack.
- Redirect coinciding with ack and pop -> count=0, ins_valid=0 next cycle, fpc=target.
- Async reset asserted mid-WAIT -> outputs at reset values immediately; restart at RESET_PC.
